mips_fetch_unit: RTL

Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS core. It is the producing end of the decode controller's instruction interface: it drives `opD`/`functD`/`instrD` into decode. It also consumes the controller's next-PC selection (`pcsrcD`, `jumppcD`) to redirect fetch. Instruction memory is variable-latency with one outstanding request, so the block runs a small request FSM with a one-entry hold buffer and squashes wrong-path responses.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/fetch_ifid_reg.sv | 24 ++
 rtl/mips_fetch_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
// Imported by the fetch unit and its IF/ID register.
package mips_pkg;

  typedef enum logic [1:0] {
    S_RESET,
    S_WAIT,
    S_HOLD,
    S_DROP
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pcplus4: 32'h0, valid: 1'b0};

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [31:0] nextWordPc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid flag.
// Clear beats enable, so a flush lands even while decode is stalled.
module fetch_ifid_reg
  import mips_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  logic  clear,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= IFID_BUBBLE;
    end else if (clear) begin
      q <= IFID_BUBBLE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch with a single-outstanding-request memory interface,
// a one-word hold buffer for stalls, and squashing of wrong-path responses.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallD,
  input  logic        flushD,
  input  logic [1:0]  pcsrcD,
  input  logic        jumppcD,
  input  logic [31:0] pcbranchD,
  input  logic [31:0] jrtargetD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [5:0]  opD,
  output logic [5:0]  functD,
  output logic [31:0] pcplus4D,
  output logic        validD,
  output logic        fetch_busy
);

  localparam logic [31:0] START_PC = RESET_PC & WORD_MASK;

  fetch_state_t state, stateNext;
  logic [31:0]  pcF, pcFNext;
  logic [31:0]  redirPc, redirPcNext;
  logic [31:0]  holdBuf, holdBufNext;
  logic [31:0]  pcPlus4F;
  logic [31:0]  redirTargetRaw, redirTarget;
  logic         redirect;
  ifid_t        ifidD, ifidQ;

  assign pcPlus4F = nextWordPc(pcF);

  // Only a real instruction in decode may steer fetch.
  assign redirect = ifidQ.valid & ~stallD & (jumppcD | (pcsrcD != 2'b00));

  always_comb begin
    if (jumppcD) begin
      redirTargetRaw = jrtargetD;
    end else if (pcsrcD[1]) begin
      redirTargetRaw = {ifidQ.pcplus4[31:28], ifidQ.instr[25:0], 2'b00};
    end else begin
      redirTargetRaw = pcbranchD;
    end
  end

  assign redirTarget = redirTargetRaw & WORD_MASK;

  always_comb begin
    stateNext   = state;
    pcFNext     = pcF;
    redirPcNext = redirPc;
    holdBufNext = holdBuf;
    ifidD       = IFID_BUBBLE;
    imem_req    = 1'b0;
    fetch_busy  = 1'b0;
    case (state)
      S_RESET: begin
        fetch_busy = 1'b1;
        pcFNext    = START_PC;
        stateNext  = S_WAIT;
      end
      S_WAIT: begin
        imem_req   = 1'b1;
        fetch_busy = ~imem_rvalid;
        if (redirect) begin
          // Anything arriving now is wrong-path; without it, the old request is still in flight.
          if (imem_rvalid) begin
            pcFNext = redirTarget;
          end else begin
            redirPcNext = redirTarget;
            stateNext   = S_DROP;
          end
        end else if (imem_rvalid) begin
          if (stallD) begin
            holdBufNext = imem_rdata;
            stateNext   = S_HOLD;
          end else begin
            ifidD   = '{instr: imem_rdata, pcplus4: pcPlus4F, valid: 1'b1};
            pcFNext = pcPlus4F;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pcFNext   = redirTarget;
          stateNext = S_WAIT;
        end else if (!stallD) begin
          ifidD     = '{instr: holdBuf, pcplus4: pcPlus4F, valid: 1'b1};
          pcFNext   = pcPlus4F;
          stateNext = S_WAIT;
        end
      end
      S_DROP: begin
        imem_req   = 1'b1;
        fetch_busy = 1'b1;
        if (redirect) begin
          redirPcNext = redirTarget;
        end
        if (imem_rvalid) begin
          pcFNext   = redirect ? redirTarget : redirPc;
          stateNext = S_WAIT;
        end
      end
      default: begin
        stateNext = S_RESET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_RESET;
      pcF     <= START_PC;
      redirPc <= START_PC;
      holdBuf <= NOP_INSTR;
    end else begin
      state   <= stateNext;
      pcF     <= pcFNext;
      redirPc <= redirPcNext;
      holdBuf <= holdBufNext;
    end
  end

  fetch_ifid_reg u_ifid (
    .clk   (clk),
    .reset (reset),
    .en    (~stallD),
    .clear (flushD | redirect),
    .d     (ifidD),
    .q     (ifidQ)
  );

  assign imem_addr = pcF;
  assign instrD    = ifidQ.instr;
  assign opD       = ifidQ.instr[31:26];
  assign functD    = ifidQ.instr[5:0];
  assign pcplus4D  = ifidQ.pcplus4;
  assign validD    = ifidQ.valid;

endmodule
